// File: rtl/regfile_pkg.sv
// Constants and helpers shared by the register-file write bank and its read muxes.
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  // Widest register the byte-merge helper supports; narrower buses are zero-extended.
  localparam int MAX_DATA_W = 128;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0]   old_val,
    input logic [MAX_DATA_W-1:0]   new_val,
    input logic [MAX_DATA_W/8-1:0] mask
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_val;
    for (int b = 0; b < MAX_DATA_W / 8; b++) begin
      if (mask[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/decoder5to32.sv
// Write-address decoder: one-hot load vector for the register bank, all-zero when idle.
module decoder5to32
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Storage and write port of the general register file: 32 byte-masked registers,
// one-hot write decode, and the per-write status pulses.
module regfile_write_bank
  import regfile_pkg::*;
#(
  parameter int                      DATA_W    = regfile_pkg::DATA_W,
  parameter bit                      ZERO_REG  = 1'b1,
  parameter logic [DATA_W-1:0]       RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   R00, R01, R02, R03, R04, R05, R06, R07,
  output logic [DATA_W-1:0]   R08, R09, R10, R11, R12, R13, R14, R15,
  output logic [DATA_W-1:0]   R16, R17, R18, R19, R20, R21, R22, R23,
  output logic [DATA_W-1:0]   R24, R25, R26, R27, R28, R29, R30, R31,
  output logic                wr_done,
  output logic                wr_ignored,
  output logic [ADDR_W-1:0]   last_addr
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] load;

  decoder5to32 u_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every register is reset because software may read any of them before writing it.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (ZERO_REG && i == 0) ? '0 : RESET_VAL;
      end
      wr_done    <= 1'b0;
      wr_ignored <= 1'b0;
      last_addr  <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignment so all registers update from pre-edge values.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ZERO_REG && i == 0) begin
          regs[i] <= '0;
        end else if (load[i]) begin
          regs[i] <= DATA_W'(byte_merge(MAX_DATA_W'(regs[i]), MAX_DATA_W'(wr_data),
                                        (MAX_DATA_W/8)'(byte_en)));
        end
      end
      wr_done    <= wr_en;
      wr_ignored <= ZERO_REG && load[0];
      if (wr_en) last_addr <= wr_addr;
    end
  end

  assign R00 = regs[0];  assign R01 = regs[1];  assign R02 = regs[2];  assign R03 = regs[3];
  assign R04 = regs[4];  assign R05 = regs[5];  assign R06 = regs[6];  assign R07 = regs[7];
  assign R08 = regs[8];  assign R09 = regs[9];  assign R10 = regs[10]; assign R11 = regs[11];
  assign R12 = regs[12]; assign R13 = regs[13]; assign R14 = regs[14]; assign R15 = regs[15];
  assign R16 = regs[16]; assign R17 = regs[17]; assign R18 = regs[18]; assign R19 = regs[19];
  assign R20 = regs[20]; assign R21 = regs[21]; assign R22 = regs[22]; assign R23 = regs[23];
  assign R24 = regs[24]; assign R25 = regs[25]; assign R26 = regs[26]; assign R27 = regs[27];
  assign R28 = regs[28]; assign R29 = regs[29]; assign R30 = regs[30]; assign R31 = regs[31];

endmodule

// File: tb/tb_regfile_write_bank.sv
// Bench for regfile_write_bank: directed scenarios plus random traffic on two instances
// (hard-wired R00 and ordinary R00) against an array-based reference model.
module tb_regfile_write_bank;

  localparam logic [31:0] N_RESET_VAL = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  byte_en;

  logic [31:0] z_r [32];
  logic [31:0] n_r [32];
  logic        z_done, z_ign, n_done, n_ign;
  logic [4:0]  z_last, n_last;

  // Reference model state
  logic [31:0] mz [32];
  logic [31:0] mn [32];
  logic        m_done, m_ign_z;
  logic [4:0]  m_last;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  regfile_write_bank #(.DATA_W(32), .ZERO_REG(1'b1), .RESET_VAL(32'h0)) dut_z (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .byte_en(byte_en),
    .R00(z_r[0]),  .R01(z_r[1]),  .R02(z_r[2]),  .R03(z_r[3]),  .R04(z_r[4]),  .R05(z_r[5]),
    .R06(z_r[6]),  .R07(z_r[7]),  .R08(z_r[8]),  .R09(z_r[9]),  .R10(z_r[10]), .R11(z_r[11]),
    .R12(z_r[12]), .R13(z_r[13]), .R14(z_r[14]), .R15(z_r[15]), .R16(z_r[16]), .R17(z_r[17]),
    .R18(z_r[18]), .R19(z_r[19]), .R20(z_r[20]), .R21(z_r[21]), .R22(z_r[22]), .R23(z_r[23]),
    .R24(z_r[24]), .R25(z_r[25]), .R26(z_r[26]), .R27(z_r[27]), .R28(z_r[28]), .R29(z_r[29]),
    .R30(z_r[30]), .R31(z_r[31]),
    .wr_done(z_done), .wr_ignored(z_ign), .last_addr(z_last)
  );

  regfile_write_bank #(.DATA_W(32), .ZERO_REG(1'b0), .RESET_VAL(N_RESET_VAL)) dut_n (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .byte_en(byte_en),
    .R00(n_r[0]),  .R01(n_r[1]),  .R02(n_r[2]),  .R03(n_r[3]),  .R04(n_r[4]),  .R05(n_r[5]),
    .R06(n_r[6]),  .R07(n_r[7]),  .R08(n_r[8]),  .R09(n_r[9]),  .R10(n_r[10]), .R11(n_r[11]),
    .R12(n_r[12]), .R13(n_r[13]), .R14(n_r[14]), .R15(n_r[15]), .R16(n_r[16]), .R17(n_r[17]),
    .R18(n_r[18]), .R19(n_r[19]), .R20(n_r[20]), .R21(n_r[21]), .R22(n_r[22]), .R23(n_r[23]),
    .R24(n_r[24]), .R25(n_r[25]), .R26(n_r[26]), .R27(n_r[27]), .R28(n_r[28]), .R29(n_r[29]),
    .R30(n_r[30]), .R31(n_r[31]),
    .wr_done(n_done), .wr_ignored(n_ign), .last_addr(n_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply merge rule: each enabled byte takes the new data, the rest keep the old value.
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  task automatic model_edge(input logic rst, input logic en, input logic [4:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mz[i] = 32'h0;
        mn[i] = N_RESET_VAL;
      end
      m_done = 1'b0; m_ign_z = 1'b0; m_last = 5'd0;
    end else begin
      m_done  = en;
      m_ign_z = en && (a == 5'd0);
      if (en) begin
        m_last = a;
        if (a != 5'd0) mz[a] = merge(mz[a], d, be);
        mn[a] = merge(mn[a], d, be);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 32; i++) begin
      check($sformatf("z.R%02d", i), z_r[i], mz[i]);
      check($sformatf("n.R%02d", i), n_r[i], mn[i]);
    end
    check("z.wr_done",    {31'b0, z_done}, {31'b0, m_done});
    check("n.wr_done",    {31'b0, n_done}, {31'b0, m_done});
    check("z.wr_ignored", {31'b0, z_ign},  {31'b0, m_ign_z});
    check("n.wr_ignored", {31'b0, n_ign},  32'h0);
    check("z.last_addr",  {27'b0, z_last}, {27'b0, m_last});
    check("n.last_addr",  {27'b0, n_last}, {27'b0, m_last});
  endtask

  // Inputs are driven after a negedge, the edge is taken, outputs are checked on the next negedge.
  task automatic cycle(input logic rst, input logic en, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    reset = rst; wr_en = en; wr_addr = a; wr_data = d; byte_en = be;
    @(posedge clk);
    model_edge(rst, en, a, d, be);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; byte_en = '0;
    @(negedge clk);

    // Reset beats a simultaneous write
    cycle(1'b1, 1'b1, 5'd5, 32'hCAFE_F00D, 4'hF);
    cycle(1'b1, 1'b1, 5'd5, 32'hCAFE_F00D, 4'hF);
    check("R05 after reset", z_r[5], 32'h0);

    // Full write, then partial byte write to the same register
    cycle(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 4'hF);
    check("R07 full write", z_r[7], 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1, 5'd7, 32'h1122_3344, 4'b0101);
    check("R07 byte write", z_r[7], 32'hDE22_BE44);
    check("last_addr 7", {27'b0, z_last}, 32'd7);

    // R00 write: ignored on the hard-wired instance, stored on the other
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF);
    check("z R00 ignored", z_r[0], 32'h0);
    check("z wr_ignored", {31'b0, z_ign}, 32'h1);
    check("n R00 written", n_r[0], 32'hFFFF_FFFF);

    // byte_en = 0 still counts as an accepted write
    cycle(1'b0, 1'b1, 5'd9, 32'h5555_5555, 4'h0);
    check("be0 wr_done", {31'b0, z_done}, 32'h1);
    cycle(1'b0, 1'b0, 5'd3, 32'h7777_7777, 4'hF);
    check("idle wr_done", {31'b0, z_done}, 32'h0);

    // 32 back-to-back writes
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 4'hF);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);

    // Read-mux sweep over the bank outputs
    for (int s = 0; s < 32; s++) begin
      logic [31:0] mux_out;
      mux_out = z_r[s];
      check($sformatf("mux sel %0d", s), mux_out, (s == 0) ? 32'h0 : 32'(s) * 32'h0101_0101);
    end

    // Burst interrupted by reset at i=10
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 5'(i), ~(32'(i) * 32'h0101_0101), 4'hF);
    cycle(1'b1, 1'b1, 5'd10, 32'hA0A0_A0A0, 4'hF);
    check("R10 write lost", z_r[10], 32'h0);
    for (int i = 11; i < 16; i++) cycle(1'b0, 1'b1, 5'(i), 32'hB000_0000 + 32'(i), 4'hF);

    // Random traffic, including occasional resets and idles with garbage inputs
    for (int k = 0; k < 400; k++) begin
      logic       rst, en;
      logic [4:0] a;
      rst = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      cycle(rst, en, a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
